i2s_master_ctrl: RTL and testbench

I2S_MASTER_CTRL -- requirements
Module: i2s_master_ctrl

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_master_ctrl_if.sv | 42 ++++
 rtl/i2s_frame_counter.sv | 95 +++++++++
 rtl/i2s_master_ctrl.sv | 135 +++++++++++++
 tb/tb_i2s_master_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S master controller:
//   I2S_BITSIZE : default sample width in bits
//   I2S_WORD    : default slot width in sclk cycles (one frame = 2*WORD)
//   i2s_state_e : controller run state (IDLE / RUN)
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int I2S_BITSIZE = 24;
    localparam int I2S_WORD    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/i2s_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// i2s_master_ctrl_if
// Bundles the I2S master's run control, serial pins and sample handshakes.
//   en                 run enable
//   lrclk, sdata_out   word select and serial transmit data (MSB first)
//   sdata_in           serial receive data
//   rx_left/right      last received sample pair, rx_valid strobes on update
//   tx_left/right      sample pair to transmit, tx_valid/tx_ready handshake
//   underrun           sticky empty-at-frame-start flag, underrun_clr clears
// modport master : the controller side; modport slave : the system side.
// ---------------------------------------------------------------------------
interface i2s_master_ctrl_if
    import i2s_pkg::*;
#(
    parameter int BITSIZE = I2S_BITSIZE
);

    logic               en;
    logic               lrclk;
    logic               sdata_out;
    logic               sdata_in;
    logic [BITSIZE-1:0] rx_left;
    logic [BITSIZE-1:0] rx_right;
    logic               rx_valid;
    logic [BITSIZE-1:0] tx_left;
    logic [BITSIZE-1:0] tx_right;
    logic               tx_valid;
    logic               tx_ready;
    logic               underrun;
    logic               underrun_clr;

    modport master (
        input  en, sdata_in, tx_left, tx_right, tx_valid, underrun_clr,
        output lrclk, sdata_out, rx_left, rx_right, rx_valid, tx_ready, underrun
    );

    modport slave (
        output en, sdata_in, tx_left, tx_right, tx_valid, underrun_clr,
        input  lrclk, sdata_out, rx_left, rx_right, rx_valid, tx_ready, underrun
    );

endinterface

// File: rtl/i2s_frame_counter.sv
// ---------------------------------------------------------------------------
// i2s_frame_counter
// Run state, frame bit counter and slot decodes for the I2S master.
//   sclk, rst       clock, synchronous active-low reset
//   i_en            run enable
//   o_lrclk         registered word select, aligned with the current bcnt
//   o_frame_start   this edge is a frame-start load (IDLE->RUN or wrap)
//   o_frame_end     this edge completes a frame (bcnt = 2*WORD-1, running)
//   o_tx_shift      this edge presents the next tx bit on sdata_out
//   o_rx_sample     this edge samples sdata_in (slot position 1..BITSIZE)
// ---------------------------------------------------------------------------
module i2s_frame_counter
    import i2s_pkg::*;
#(
    parameter int WORD    = I2S_WORD,
    parameter int BITSIZE = I2S_BITSIZE
) (
    input  logic sclk,
    input  logic rst,
    input  logic i_en,
    output logic o_lrclk,
    output logic o_frame_start,
    output logic o_frame_end,
    output logic o_tx_shift,
    output logic o_rx_sample
);

    localparam int            CW     = $clog2(2 * WORD);
    localparam logic [CW-1:0] C_LAST = CW'(2 * WORD - 1);
    localparam logic [CW-1:0] C_WORD = CW'(WORD);
    localparam logic [CW-1:0] C_BITS = CW'(BITSIZE);

    i2s_state_e    r_state;
    i2s_state_e    w_state_nxt;
    logic [CW-1:0] r_bcnt;
    logic [CW-1:0] w_bcnt_nxt;
    logic [CW-1:0] w_p;
    logic          r_lrclk;
    logic          w_lrclk_nxt;
    logic          w_run;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        unique case (r_state)
            IDLE: begin
                if (i_en) begin
                    w_state_nxt = RUN;
                    w_bcnt_nxt  = '0;
                end
            end
            RUN: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                    w_bcnt_nxt  = '0;
                end else if (r_bcnt == C_LAST) begin
                    w_bcnt_nxt = '0;
                end else begin
                    w_bcnt_nxt = r_bcnt + CW'(1);
                end
            end
            default: ;
        endcase
        // lrclk is registered from the next count so it lines up with bcnt.
        w_lrclk_nxt = (w_state_nxt == RUN) && (w_bcnt_nxt >= C_WORD);
    end

    always_ff @(posedge sclk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (!rst) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_lrclk <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_lrclk <= w_lrclk_nxt;
        end
    end

    assign w_run = (r_state == RUN);
    assign w_p   = (r_bcnt >= C_WORD) ? (r_bcnt - C_WORD) : r_bcnt;

    assign o_lrclk       = r_lrclk;
    assign o_frame_start = i_en && (!w_run || (r_bcnt == C_LAST));
    assign o_frame_end   = w_run && i_en && (r_bcnt == C_LAST);
    // Shifting at p makes bit p+1 visible during the next cycle; the slot
    // never changes across such an edge because BITSIZE < WORD.
    assign o_tx_shift    = w_run && i_en && (w_p < C_BITS);
    assign o_rx_sample   = w_run && (w_p != '0) && (w_p <= C_BITS);

endmodule

// File: rtl/i2s_master_ctrl.sv
// ---------------------------------------------------------------------------
// i2s_master_ctrl
// I2S master: generates lrclk, shifts a stereo sample pair out on sdata_out
// with the one-bit I2S delay, deserialises sdata_in into rx_left/rx_right,
// and double-buffers transmit samples through a one-deep holding register.
//   sclk  sole clock (posedge)
//   rst   synchronous active-low reset
//   bus   i2s_master_ctrl_if.master (run control, serial pins, handshakes)
// ---------------------------------------------------------------------------
module i2s_master_ctrl
    import i2s_pkg::*;
#(
    parameter int BITSIZE = I2S_BITSIZE,
    parameter int WORD    = I2S_WORD
) (
    input  logic              sclk,
    input  logic              rst,
    i2s_master_ctrl_if.master bus
);

    logic               w_lrclk;
    logic               w_frame_start;
    logic               w_frame_end;
    logic               w_tx_shift;
    logic               w_rx_sample;
    logic               w_tx_accept;

    logic               r_sdata_out;
    logic               r_rx_valid;
    logic               r_hold_full;
    logic               r_underrun;
    logic [BITSIZE-1:0] r_tx_l_sh;
    logic [BITSIZE-1:0] r_tx_r_sh;
    logic [BITSIZE-1:0] r_rx_l_sh;
    logic [BITSIZE-1:0] r_rx_r_sh;
    logic [BITSIZE-1:0] r_rx_left;
    logic [BITSIZE-1:0] r_rx_right;
    logic [BITSIZE-1:0] r_hold_l;
    logic [BITSIZE-1:0] r_hold_r;

    i2s_frame_counter #(
        .WORD    (WORD),
        .BITSIZE (BITSIZE)
    ) u_frame_counter (
        .sclk          (sclk),
        .rst           (rst),
        .i_en          (bus.en),
        .o_lrclk       (w_lrclk),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end),
        .o_tx_shift    (w_tx_shift),
        .o_rx_sample   (w_rx_sample)
    );

    // tx_ready is a pure register output, so accept never loops back on tx_valid.
    assign w_tx_accept = bus.tx_valid && !r_hold_full;

    // NOTE: the holding data needs no reset: it is only ever read while
    // r_hold_full is set, and r_hold_full itself is reset.
    always_ff @(posedge sclk) begin
        if (w_tx_accept) begin
            r_hold_l <= bus.tx_left;
            r_hold_r <= bus.tx_right;
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst) begin
            r_sdata_out <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_hold_full <= 1'b0;
            r_underrun  <= 1'b0;
            r_tx_l_sh   <= '0;
            r_tx_r_sh   <= '0;
            r_rx_l_sh   <= '0;
            r_rx_r_sh   <= '0;
            r_rx_left   <= '0;
            r_rx_right  <= '0;
        end else begin
            // Transmit: load at frame start (zeros when starved), else shift.
            r_sdata_out <= 1'b0;
            if (w_frame_start) begin
                r_tx_l_sh <= r_hold_full ? r_hold_l : '0;
                r_tx_r_sh <= r_hold_full ? r_hold_r : '0;
            end else if (w_tx_shift) begin
                if (w_lrclk) begin
                    r_sdata_out <= r_tx_r_sh[BITSIZE-1];
                    r_tx_r_sh   <= r_tx_r_sh << 1;
                end else begin
                    r_sdata_out <= r_tx_l_sh[BITSIZE-1];
                    r_tx_l_sh   <= r_tx_l_sh << 1;
                end
            end

            // Receive: MSB first into the slot's shift register.
            if (w_rx_sample) begin
                if (w_lrclk) begin
                    r_rx_r_sh <= BITSIZE'({r_rx_r_sh, bus.sdata_in});
                end else begin
                    r_rx_l_sh <= BITSIZE'({r_rx_l_sh, bus.sdata_in});
                end
            end

            // Only a completed frame publishes; an abort never reaches here.
            r_rx_valid <= w_frame_end;
            if (w_frame_end) begin
                r_rx_left  <= r_rx_l_sh;
                r_rx_right <= r_rx_r_sh;
            end

            // Accept (only possible when empty) and frame-start drain are exclusive.
            if (w_tx_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_frame_start) begin
                r_hold_full <= 1'b0;
            end

            // A starved frame start wins over a coincident clear.
            if (w_frame_start && !r_hold_full) begin
                r_underrun <= 1'b1;
            end else if (bus.underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign bus.lrclk     = w_lrclk;
    assign bus.sdata_out = r_sdata_out;
    assign bus.rx_left   = r_rx_left;
    assign bus.rx_right  = r_rx_right;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.tx_ready  = !r_hold_full;
    assign bus.underrun  = r_underrun;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2s_master_ctrl
// Self-checking bench for i2s_master_ctrl. A frame-level reference model
// (frame position, holding slot, per-position rx bit arrays) predicts every
// output each cycle; directed checks cover the frame contents, underrun
// behaviour, abort/re-enable and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_i2s_master_ctrl;
    import i2s_pkg::*;

    localparam int BITSIZE = I2S_BITSIZE;
    localparam int WORD    = I2S_WORD;
    localparam int FRAME   = 2 * WORD;

    logic sclk;
    logic rst;

    i2s_master_ctrl_if #(.BITSIZE(BITSIZE)) bus ();

    i2s_master_ctrl #(
        .BITSIZE (BITSIZE),
        .WORD    (WORD)
    ) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                 m_run;
    int                 m_pos;
    bit                 m_hold_full;
    logic [BITSIZE-1:0] m_hold_l, m_hold_r;
    logic [BITSIZE-1:0] m_frame_l, m_frame_r;
    bit                 m_underrun;
    bit                 m_rx_valid;
    logic [BITSIZE-1:0] m_rx_left, m_rx_right;
    logic [BITSIZE-1:0] m_rxa_l, m_rxa_r;
    bit                 m_last_acc;

    function automatic logic exp_sdata();
        int p = m_pos % WORD;
        if (!m_run || p < 1 || p > BITSIZE) return 1'b0;
        return (m_pos >= WORD) ? m_frame_r[BITSIZE-p] : m_frame_l[BITSIZE-p];
    endfunction

    // Advances the model across one rising edge using the bench-driven inputs.
    task automatic model_edge();
        int p;
        bit fs, fe;
        m_last_acc = 1'b0;
        if (!rst) begin
            m_run = 0; m_pos = 0; m_hold_full = 0; m_underrun = 0; m_rx_valid = 0;
            m_rx_left = '0; m_rx_right = '0; m_frame_l = '0; m_frame_r = '0;
            m_rxa_l = '0; m_rxa_r = '0;
            return;
        end
        p  = m_pos % WORD;
        fs = bus.en && (!m_run || m_pos == FRAME - 1);
        fe = m_run && bus.en && m_pos == FRAME - 1;
        m_last_acc = bus.tx_valid && !m_hold_full;
        if (m_run && p >= 1 && p <= BITSIZE) begin
            if (m_pos >= WORD) m_rxa_r[BITSIZE-p] = bus.sdata_in;
            else               m_rxa_l[BITSIZE-p] = bus.sdata_in;
        end
        m_rx_valid = fe;
        if (fe) begin
            m_rx_left  = m_rxa_l;
            m_rx_right = m_rxa_r;
        end
        if (fs && !m_hold_full)   m_underrun = 1;
        else if (bus.underrun_clr) m_underrun = 0;
        if (fs) begin
            m_frame_l   = m_hold_full ? m_hold_l : '0;
            m_frame_r   = m_hold_full ? m_hold_r : '0;
            m_hold_full = 0;
        end
        if (m_last_acc) begin
            m_hold_l    = bus.tx_left;
            m_hold_r    = bus.tx_right;
            m_hold_full = 1;
        end
        if (!m_run) begin
            if (bus.en) begin m_run = 1; m_pos = 0; end
        end else if (!bus.en) begin
            m_run = 0; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    // ---------------- bench state ----------------
    bit                 rx_loop, feed, rv_track, feed_track;
    int                 cyc, rv_last, acc_seen;
    logic [BITSIZE-1:0] obs_l, obs_r, last_acc_l, last_acc_r;

    task automatic cycle();
        int p;
        if (feed_track && bus.tx_valid && bus.tx_ready) acc_seen++;
        if (feed_track && m_run && bus.en && m_pos == FRAME - 1) begin
            check("accepts_per_frame", 32'(acc_seen), 32'd1);
            acc_seen = 0;
        end
        @(posedge sclk);
        model_edge();
        #1;
        cyc++;
        check("lrclk",     32'(bus.lrclk),     32'(m_run && m_pos >= WORD));
        check("sdata_out", 32'(bus.sdata_out), 32'(exp_sdata()));
        check("tx_ready",  32'(bus.tx_ready),  32'(!m_hold_full));
        check("underrun",  32'(bus.underrun),  32'(m_underrun));
        check("rx_valid",  32'(bus.rx_valid),  32'(m_rx_valid));
        check("rx_left",   32'(bus.rx_left),   32'(m_rx_left));
        check("rx_right",  32'(bus.rx_right),  32'(m_rx_right));
        p = m_pos % WORD;
        if (m_run && p >= 1 && p <= BITSIZE) begin
            if (m_pos >= WORD) obs_r[BITSIZE-p] = bus.sdata_out;
            else               obs_l[BITSIZE-p] = bus.sdata_out;
        end
        if (rv_track && bus.rx_valid) begin
            if (rv_last >= 0) check("rx_valid_period", 32'(cyc - rv_last), 32'(FRAME));
            rv_last = cyc;
        end
        if (feed) begin
            if (m_last_acc) begin
                last_acc_l   = bus.tx_left;
                last_acc_r   = bus.tx_right;
                bus.tx_left  = BITSIZE'($urandom);
                bus.tx_right = BITSIZE'($urandom);
            end
            bus.tx_valid = 1'b1;
        end
        bus.sdata_in = rx_loop ? bus.sdata_out : 1'($urandom);
    endtask

    // Model-driven, so the bound only guards against a bench mistake.
    task automatic run_to(input int pos);
        for (int n = 0; n < 2 * FRAME && !(m_run && m_pos == pos); n++) cycle();
    endtask

    logic [BITSIZE-1:0] und_l, und_r;
    int                 rv_cnt;

    initial begin
        rx_loop = 0; feed = 0; rv_track = 0; feed_track = 0;
        cyc = 0; rv_last = -1; acc_seen = 0;
        obs_l = '0; obs_r = '0; last_acc_l = '0; last_acc_r = '0;

        // Reset dominates every other input.
        rst = 1'b0; bus.en = 1'b1; bus.tx_valid = 1'b1; bus.underrun_clr = 1'b1;
        bus.tx_left = BITSIZE'($urandom); bus.tx_right = BITSIZE'($urandom);
        bus.sdata_in = 1'b1;
        repeat (3) cycle();
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_lrclk",    32'(bus.lrclk),    32'd0);

        // Pre-load the holding register while idle.
        rst = 1'b1; bus.en = 1'b0; bus.underrun_clr = 1'b0;
        bus.tx_valid = 1'b1; bus.tx_left = 24'hABCDEF; bus.tx_right = 24'h123456;
        cycle();
        bus.tx_valid = 1'b0;
        check("preload_not_ready", 32'(bus.tx_ready), 32'd0);
        repeat (2) cycle();

        // First frame, loopback, continuous tx_valid.
        rx_loop = 1; feed = 1; bus.tx_valid = 1'b1;
        bus.tx_left = BITSIZE'($urandom); bus.tx_right = BITSIZE'($urandom);
        bus.en = 1'b1;
        run_to(FRAME - 1);
        check("frame1_left",  32'(obs_l), 32'h00ABCDEF);
        check("frame1_right", 32'(obs_r), 32'h00123456);
        check("frame1_no_underrun", 32'(bus.underrun), 32'd0);
        cycle();
        check("loop_rx_valid", 32'(bus.rx_valid), 32'd1);
        check("loop_rx_left",  32'(bus.rx_left),  32'h00ABCDEF);
        check("loop_rx_right", 32'(bus.rx_right), 32'h00123456);
        acc_seen = 0; feed_track = 1; rv_last = -1; rv_track = 1;
        repeat (4 * FRAME) cycle();

        // Random receive data.
        rx_loop = 0;
        repeat (2 * FRAME) cycle();

        // Starve the holding register.
        rx_loop = 1; feed = 0; feed_track = 0; rv_track = 0; bus.tx_valid = 1'b0;
        run_to(FRAME - 1);
        cycle();
        check("underrun_set", 32'(bus.underrun), 32'd1);
        bus.underrun_clr = 1'b1;
        cycle();
        bus.underrun_clr = 1'b0;
        check("underrun_cleared", 32'(bus.underrun), 32'd0);
        run_to(FRAME - 1);
        und_l = BITSIZE'($urandom); und_r = BITSIZE'($urandom);
        bus.underrun_clr = 1'b1; bus.tx_valid = 1'b1;
        bus.tx_left = und_l; bus.tx_right = und_r;
        cycle();
        bus.underrun_clr = 1'b0; bus.tx_valid = 1'b0;
        check("underrun_set_priority", 32'(bus.underrun), 32'd1);
        check("late_accept_held",      32'(bus.tx_ready), 32'd0);
        run_to(FRAME - 1);
        cycle();
        run_to(FRAME - 1);
        check("late_pair_left",  32'(obs_l), 32'(und_l));
        check("late_pair_right", 32'(obs_r), 32'(und_r));

        // Abort mid-frame, then resume with the holding register intact.
        feed = 1; bus.tx_valid = 1'b1;
        bus.tx_left = BITSIZE'($urandom); bus.tx_right = BITSIZE'($urandom);
        cycle();
        run_to(40);
        feed = 0; bus.tx_valid = 1'b0; bus.en = 1'b0;
        cycle();
        check("abort_lrclk", 32'(bus.lrclk),     32'd0);
        check("abort_sdata", 32'(bus.sdata_out), 32'd0);
        rv_cnt = 32'(bus.rx_valid);
        repeat (6) begin
            cycle();
            rv_cnt += 32'(bus.rx_valid);
        end
        check("abort_no_rx_valid", 32'(rv_cnt),       32'd0);
        check("abort_hold_kept",   32'(bus.tx_ready), 32'd0);
        bus.en = 1'b1;
        run_to(FRAME - 1);
        check("resume_left",  32'(obs_l), 32'(last_acc_l));
        check("resume_right", 32'(obs_r), 32'(last_acc_r));

        // Reset on the last cycle of a frame.
        rst = 1'b0;
        cycle();
        check("rst63_rx_valid", 32'(bus.rx_valid),  32'd0);
        check("rst63_underrun", 32'(bus.underrun),  32'd0);
        check("rst63_tx_ready", 32'(bus.tx_ready),  32'd1);
        check("rst63_rx_left",  32'(bus.rx_left),   32'd0);
        check("rst63_sdata",    32'(bus.sdata_out), 32'd0);
        rst = 1'b1; bus.en = 1'b0;
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
